// File: rtl/circ_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// circ_buffer_ctrl
//   Circular data buffer with write/read pointer management. Feeds the Round
//   wrap-flag stage of the convolution engine operand path: raw Push/Pop
//   requests are gated into accepted strobes, pointers advance with wrap, and
//   Full/Empty/Count are derived from pointer equality plus the round bit.
//
// Parameters
//   BufferWidth  address width in bits
//   BufferSize   number of entries, must equal 2**BufferWidth
//   DataWidth    width of one stored entry
//
// Ports
//   clk        rising-edge clock
//   sclr_n     synchronous clear, active-low (pointers/flags only, not storage)
//   Push       write request, W_Data sampled with it
//   Pop        read request
//   W_Data     write data
//   R_Data     registered read data, valid when R_Valid
//   R_Valid    one-cycle pulse, one cycle after an accepted Pop
//   Push_Acc   combinational, Push accepted this cycle
//   Pop_Acc    combinational, Pop accepted this cycle
//   W_Addr     current write pointer
//   R_Addr     current read pointer
//   Round      write pointer is one wrap ahead of the read pointer
//   Full       combinational from registers, BufferSize entries held
//   Empty      combinational from registers, no entries held
//   Count      registered occupancy, 0..BufferSize
//
// Optional feature (macro CIRC_BUFFER_ERR_EN)
//   Overflow   sticky, set by Push while Full
//   Underflow  sticky, set by Pop while Empty
//   Both cleared only by sclr_n. Without the macro the ports are absent and
//   rejected requests are silently dropped.
// ---------------------------------------------------------------------------
module circ_buffer_ctrl #(
  parameter int unsigned BufferWidth = 4,
  parameter int unsigned BufferSize  = 16,
  parameter int unsigned DataWidth   = 8
) (
  input  logic                   clk,
  input  logic                   sclr_n,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic [DataWidth-1:0]   W_Data,
  output logic [DataWidth-1:0]   R_Data,
  output logic                   R_Valid,
  output logic                   Push_Acc,
  output logic                   Pop_Acc,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic                   Full,
  output logic                   Empty,
  output logic [BufferWidth:0]   Count
`ifdef CIRC_BUFFER_ERR_EN
  ,
  output logic                   Overflow,
  output logic                   Underflow
`endif
);

  localparam int unsigned CountWidth = BufferWidth + 1;
  localparam logic [BufferWidth-1:0] LastAddr = BufferWidth'(BufferSize - 1);

  // Pointer wrap relies on natural modulo arithmetic of the address width.
  if (BufferSize != (1 << BufferWidth)) begin : g_bad_size
    $error("circ_buffer_ctrl: BufferSize must equal 2**BufferWidth");
  end

  logic [DataWidth-1:0]   mem [BufferSize];

  logic                   ptr_eq;
  logic [BufferWidth-1:0] w_addr_nxt;
  logic [BufferWidth-1:0] r_addr_nxt;
  logic                   round_nxt;
  logic [CountWidth-1:0]  count_nxt;

  // Status flags and request gating; no bypass between push and pop.
  always_comb begin
    ptr_eq   = (W_Addr == R_Addr);
    Full     = ptr_eq && Round;
    Empty    = ptr_eq && !Round;
    Push_Acc = Push && !Full;
    Pop_Acc  = Pop && !Empty;
  end

  // Next-state for pointers, round bit and occupancy.
  always_comb begin
    w_addr_nxt = W_Addr;
    r_addr_nxt = R_Addr;
    round_nxt  = Round;
    count_nxt  = Count;

    if (Push_Acc) begin
      w_addr_nxt = W_Addr + BufferWidth'(1);
    end
    if (Pop_Acc) begin
      r_addr_nxt = R_Addr + BufferWidth'(1);
    end

    // Write wrap sets, read wrap clears; both in one cycle is unreachable.
    if (Push_Acc && (W_Addr == LastAddr)) begin
      round_nxt = 1'b1;
    end else if (Pop_Acc && (R_Addr == LastAddr)) begin
      round_nxt = 1'b0;
    end

    case ({Push_Acc, Pop_Acc})
      2'b10:   count_nxt = Count + CountWidth'(1);
      2'b01:   count_nxt = Count - CountWidth'(1);
      default: count_nxt = Count;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      W_Addr <= '0;
      R_Addr <= '0;
      Round  <= 1'b0;
      Count  <= '0;
    end else begin
      W_Addr <= w_addr_nxt;
      R_Addr <= r_addr_nxt;
      Round  <= round_nxt;
      Count  <= count_nxt;
    end
  end

  // Read port: one-cycle latency, data holds between reads.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      R_Valid <= 1'b0;
      R_Data  <= '0;
    end else begin
      R_Valid <= Pop_Acc;
      if (Pop_Acc) begin
        R_Data <= mem[R_Addr];
      end
    end
  end

  // Storage is never cleared; a clear cycle blocks the write.
  always_ff @(posedge clk) begin
    if (sclr_n && Push_Acc) begin
      mem[W_Addr] <= W_Data;
    end
  end

`ifdef CIRC_BUFFER_ERR_EN
  // Sticky error flags for requests that were refused.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (Push && Full) begin
        Overflow <= 1'b1;
      end
      if (Pop && Empty) begin
        Underflow <= 1'b1;
      end
    end
  end
`endif

  // Occupancy must always match the pointer distance extended by the round bit.
  a_count_consistent : assert property (
    @(posedge clk) disable iff (!sclr_n)
      Count == CountWidth'({Round, W_Addr} - {1'b0, R_Addr})
  );

endmodule

// File: tb/tb_circ_buffer_ctrl.sv
module tb_circ_buffer_ctrl;

  localparam int unsigned BW = 2;
  localparam int unsigned BS = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          sclr_n = 1'b0;
  logic          Push = 1'b0;
  logic          Pop = 1'b0;
  logic [DW-1:0] W_Data = '0;
  logic [DW-1:0] R_Data;
  logic          R_Valid;
  logic          Push_Acc;
  logic          Pop_Acc;
  logic [BW-1:0] W_Addr;
  logic [BW-1:0] R_Addr;
  logic          Round;
  logic          Full;
  logic          Empty;
  logic [BW:0]   Count;
`ifdef CIRC_BUFFER_ERR_EN
  logic          Overflow;
  logic          Underflow;
`endif

  circ_buffer_ctrl #(
    .BufferWidth(BW),
    .BufferSize (BS),
    .DataWidth  (DW)
  ) dut (
    .clk      (clk),
    .sclr_n   (sclr_n),
    .Push     (Push),
    .Pop      (Pop),
    .W_Data   (W_Data),
    .R_Data   (R_Data),
    .R_Valid  (R_Valid),
    .Push_Acc (Push_Acc),
    .Pop_Acc  (Pop_Acc),
    .W_Addr   (W_Addr),
    .R_Addr   (R_Addr),
    .Round    (Round),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count)
`ifdef CIRC_BUFFER_ERR_EN
    ,
    .Overflow (Overflow),
    .Underflow(Underflow)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: contents queue plus pointer counters.
  logic [DW-1:0] q[$];
  // Scoreboard: data expected on R_Data, pushed when a pop is accepted.
  logic [DW-1:0] sb[$];
  int   wp = 0;
  int   rp = 0;
  logic exp_rv = 1'b0;
  logic last_pacc;
  logic last_racc;

  function automatic logic model_round();
    return (rp + q.size()) > (BS - 1);
  endfunction

  // One clock of stimulus; checks the read output owed from the previous cycle.
  task automatic step(input logic p, input logic r, input logic [DW-1:0] d);
    logic          mp;
    logic          mr;
    logic [DW-1:0] e;
    Push = p; Pop = r; W_Data = d;
    @(negedge clk);
    total++;
    if (R_Valid !== exp_rv) begin
      bad++;
      $display("FAIL r_valid: got %b want %b at %0t", R_Valid, exp_rv, $time);
    end
    if (exp_rv) begin
      e = sb.pop_front();
      total++;
      if (R_Data !== e) begin
        bad++;
        $display("FAIL r_data: got %h want %h at %0t", R_Data, e, $time);
      end
    end
    last_pacc = Push_Acc;
    last_racc = Pop_Acc;
    mp = p && (q.size() < BS);
    mr = r && (q.size() > 0);
    @(posedge clk);
    if (mr) begin
      sb.push_back(q.pop_front());
      rp = (rp + 1) % BS;
    end
    if (mp) begin
      q.push_back(d);
      wp = (wp + 1) % BS;
    end
    exp_rv = mr;
    #1;
    Push = 1'b0; Pop = 1'b0;
  endtask

  task automatic do_reset(input logic p);
    sclr_n = 1'b0; Push = p; Pop = 1'b0; W_Data = 8'hA5;
    @(negedge clk);
    @(posedge clk);
    #1;
    sclr_n = 1'b1; Push = 1'b0;
    q.delete(); sb.delete();
    wp = 0; rp = 0; exp_rv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    total++;
    if ({Count, W_Addr, R_Addr, Round, Empty, Full, R_Valid} !== {3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d w=%0d r=%0d rnd=%b e=%b f=%b rv=%b want 0 0 0 0 1 0 0",
               Count, W_Addr, R_Addr, Round, Empty, Full, R_Valid);
    end
    total++;
    if (R_Data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 00", R_Data);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, vals[i]);
      total++;
      if (last_pacc !== 1'b1 || Count !== 3'(i + 1)) begin
        bad++;
        $display("FAIL fill_push%0d: got acc=%b cnt=%0d want acc=1 cnt=%0d", i, last_pacc, Count, i + 1);
      end
    end
    total++;
    if (Full !== 1'b1 || W_Addr !== 2'd0 || Round !== 1'b1) begin
      bad++;
      $display("FAIL fill_full: got full=%b w=%0d rnd=%b want 1 0 1", Full, W_Addr, Round);
    end
    step(1'b1, 1'b0, 8'h99);
    total++;
    if (last_pacc !== 1'b0 || Count !== 3'd4 || W_Addr !== 2'd0 || Round !== 1'b1) begin
      bad++;
      $display("FAIL fill_reject: got acc=%b cnt=%0d w=%0d rnd=%b want 0 4 0 1", last_pacc, Count, W_Addr, Round);
    end
`ifdef CIRC_BUFFER_ERR_EN
    total++;
    if (Overflow !== 1'b1 || Underflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_set: got ovf=%b unf=%b want 1 0", Overflow, Underflow);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (last_racc !== 1'b1 || Count !== 3'(3 - i)) begin
        bad++;
        $display("FAIL drain_pop%0d: got acc=%b cnt=%0d want acc=1 cnt=%0d", i, last_racc, Count, 3 - i);
      end
    end
    total++;
    if (Round !== 1'b0 || Empty !== 1'b1 || R_Addr !== 2'd0) begin
      bad++;
      $display("FAIL drain_empty: got rnd=%b empty=%b r=%0d want 0 1 0", Round, Empty, R_Addr);
    end
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (last_racc !== 1'b0 || Count !== 3'd0) begin
      bad++;
      $display("FAIL drain_reject: got acc=%b cnt=%0d want 0 0", last_racc, Count);
    end
`ifdef CIRC_BUFFER_ERR_EN
    total++;
    if (Underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_set: got %b want 1", Underflow);
    end
`endif
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    step(1'b1, 1'b1, 8'hEE);
    total++;
    if (last_racc !== 1'b1 || last_pacc !== 1'b0 || Count !== 3'd3 || W_Addr !== 2'd0) begin
      bad++;
      $display("FAIL full_pp: got racc=%b pacc=%b cnt=%0d w=%0d want 1 0 3 0", last_racc, last_pacc, Count, W_Addr);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 1'b1, 8'h5A);
    total++;
    if (last_pacc !== 1'b1 || last_racc !== 1'b0 || Count !== 3'd1) begin
      bad++;
      $display("FAIL empty_pp: got pacc=%b racc=%b cnt=%0d want 1 0 1", last_pacc, last_racc, Count);
    end
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (last_racc !== 1'b1 || Count !== 3'd0) begin
      bad++;
      $display("FAIL empty_pp_drain: got acc=%b cnt=%0d want 1 0", last_racc, Count);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h03);
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (Count !== 3'd2 || W_Addr !== 2'd3 || R_Addr !== 2'd1) begin
      bad++;
      $display("FAIL b2b_setup: got cnt=%0d w=%0d r=%0d want 2 3 1", Count, W_Addr, R_Addr);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'(8'h10 + i));
      total++;
      if (Count !== 3'd2 || last_pacc !== 1'b1 || last_racc !== 1'b1) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got cnt=%0d pacc=%b racc=%b want 2 1 1", i, Count, last_pacc, last_racc);
      end
    end
    total++;
    if (W_Addr !== 2'd1 || R_Addr !== 2'd3 || Round !== 1'b1) begin
      bad++;
      $display("FAIL b2b_wrap: got w=%0d r=%0d rnd=%b want 1 3 1", W_Addr, R_Addr, Round);
    end
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC1 + i));
    step(1'b1, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (Count !== 3'd3) begin
      bad++;
      $display("FAIL mid_setup: got cnt=%0d want 3", Count);
    end
    do_reset(1'b1);
    total++;
    if (Count !== 3'd0 || Empty !== 1'b1 || W_Addr !== 2'd0 || R_Addr !== 2'd0 || R_Valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got cnt=%0d e=%b w=%0d r=%0d rv=%b want 0 1 0 0 0", Count, Empty, W_Addr, R_Addr, R_Valid);
    end
`ifdef CIRC_BUFFER_ERR_EN
    total++;
    if (Overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got %b want 0", Overflow);
    end
`endif
  endtask

  task automatic test_random();
    logic          p;
    logic          r;
    logic          pp;
    logic          pr;
    logic [DW-1:0] d;
    do_reset(1'b0);
    for (int i = 0; i < 80; i++) begin
      p = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      pp = p && (q.size() < BS);
      pr = r && (q.size() > 0);
      step(p, r, d);
      total++;
      if (last_pacc !== pp || last_racc !== pr) begin
        bad++;
        $display("FAIL rnd_acc%0d: got pacc=%b racc=%b want %b %b", i, last_pacc, last_racc, pp, pr);
      end
      total++;
      if (Count !== 3'(q.size()) || W_Addr !== 2'(wp) || R_Addr !== 2'(rp) || Round !== model_round() ||
          Full !== (q.size() == BS) || Empty !== (q.size() == 0)) begin
        bad++;
        $display("FAIL rnd_state%0d: got cnt=%0d w=%0d r=%0d rnd=%b f=%b e=%b want cnt=%0d w=%0d r=%0d rnd=%b",
                 i, Count, W_Addr, R_Addr, Round, Full, Empty, q.size(), wp, rp, model_round());
      end
    end
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_push_pop();
    test_empty_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circ_buffer_ctrl.md
Name: circ_buffer_ctrl

Overview:
- Circular data buffer with pointer management, placed directly upstream of the Round wrap-flag stage in the convolution engine's operand path.
- Gates raw Push/Pop requests into accepted operations, advances the write and read pointers, and stores data.
- Exports W_Addr, R_Addr, the gated Push/Pop strobes, and its own round state.
- Derives Full, Empty and occupancy Count from pointer equality plus the round bit.

Parameters:
- BufferWidth, 4, address width in bits.
- BufferSize, 16, number of entries; must equal 2**BufferWidth.
- DataWidth, 8, width of one stored entry.

Ports:
- clk  input  1  rising-edge clock.
- sclr_n  input  1  synchronous clear, active-low.
- Push  input  1  write request.
- Pop  input  1  read request.
- W_Data  input  DataWidth  write data, sampled with Push.
- R_Data  output  DataWidth  registered read data.
- R_Valid  output  1  one-cycle pulse; R_Data valid.
- Push_Acc  output  1  combinational; Push accepted this cycle.
- Pop_Acc  output  1  combinational; Pop accepted this cycle.
- W_Addr  output  BufferWidth  current write pointer.
- R_Addr  output  BufferWidth  current read pointer.
- Round  output  1  write pointer has wrapped once more than the read pointer.
- Full  output  1  buffer holds BufferSize entries.
- Empty  output  1  buffer holds 0 entries.
- Count  output  BufferWidth+1  occupancy, 0..BufferSize.

Behaviour:
- All state updates on posedge clk. Reset is synchronous: sclr_n==0 at a clock edge sets:
  - W_Addr=0, R_Addr=0, Round=0, Count=0
  - R_Valid=0, R_Data=0
  - Empty=1, Full=0
- Reset mid-operation discards contents; storage array is not cleared, only pointers. Reset overrides Push/Pop in the same cycle.
- Full = (W_Addr==R_Addr) && Round. Empty = (W_Addr==R_Addr) && !Round. Both combinational from registers.
- Push_Acc = Push && !Full. Pop_Acc = Pop && !Empty. No bypass:
  - Push while Full is rejected even if Pop_Acc is asserted the same cycle.
  - Pop while Empty is rejected even if Push_Acc is asserted the same cycle.
- On Push_Acc:
  - mem[W_Addr] <= W_Data.
  - W_Addr increments; BufferSize-1 wraps to 0.
- On Pop_Acc:
  - R_Data <= mem[R_Addr]; R_Valid=1 next cycle (latency 1); otherwise R_Valid=0 and R_Data holds.
  - R_Addr increments with wrap.
- Round update:
  - Set when Push_Acc && W_Addr==BufferSize-1.
  - Else cleared when Pop_Acc && R_Addr==BufferSize-1.
  - Else held.
  - Both wraps in one cycle cannot occur (would require Full and Empty simultaneously). Set still takes priority.
- Count is registered: +1 on Push_Acc only, -1 on Pop_Acc only, unchanged on both or neither. Invariant: Count == (Round ? BufferSize : 0) + W_Addr - R_Addr, computed at BufferWidth+1 bits.
- Simultaneous accepted push and pop with W_Addr!=R_Addr:
  - Both pointers advance.
  - Read returns the old entry (read-before-write on distinct addresses only).

Optional Feature:
- CIRC_BUFFER_ERR_EN defined:
  - Adds outputs Overflow and Underflow, each 1 bit, sticky.
  - Overflow set on Push && Full; Underflow set on Pop && Empty.
  - Both cleared only by sclr_n==0.
- Undefined: ports absent; rejected requests are silently dropped.

Test Plan (BufferWidth=2, BufferSize=4, DataWidth=8):
- Reset, then push 0x11,0x22,0x33,0x44 on four cycles:
  - Count 1..4; Full=1 after 4th push; W_Addr=0; Round=1.
  - Fifth Push gives Push_Acc=0 and no state change.
- From that full state, pop four times:
  - R_Data 0x11,0x22,0x33,0x44, each one cycle after its Pop with R_Valid pulses.
  - Round clears on 4th pop; Empty=1; Pop on empty gives Pop_Acc=0.
- Full buffer, Push+Pop same cycle: Pop_Acc=1, Push_Acc=0, Count=3, W_Addr unchanged.
- Empty buffer, Push(0x5A)+Pop same cycle: Push_Acc=1, Pop_Acc=0, Count=1, R_Valid=0 next cycle.
- Count=2 at W_Addr=3, R_Addr=1, steady Push+Pop for 6 cycles: Count stays 2, pointers wrap, data order preserved.
- Count=3, assert sclr_n=0 with Push=1 for one cycle: Count=0, Empty=1, pointers 0, R_Valid=0. With CIRC_BUFFER_ERR_EN, previously set Overflow clears.
